regfile_2r1w_sb: RTL and testbench
==================================

// Module: regfile_2r1w_sb
// PURPOSE
//  Integer register file with a pending-write scoreboard. Sits directly upstream of the
//  32-bit logic/arithmetic units: rd_data_a/rd_data_b drive their a/b operand inputs, and
//  unit results (z) return via the write port. Two combinational read ports with write
//  bypass, one synchronous write port, register 0 hardwired to zero.
//  Per-register busy bits let issue logic stall on operands still in flight.
// PARAMETERS
//  DATA_W   32  register width in bits (must match the a/b/z width of the units)
//  ADDR_W   5   address width; register count NREGS = 2**ADDR_W
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  rd_addr_a    in   ADDR_W  read port A address
//  rd_data_a    out  DATA_W  read port A data (feeds unit operand a)
//  busy_a       out  1       port A register has a pending, not-yet-written result
//  rd_addr_b    in   ADDR_W  read port B address
//  rd_data_b    out  DATA_W  read port B data (feeds unit operand b)
//  busy_b       out  1       port B register has a pending, not-yet-written result
//  wr_en        in   1       write strobe; writes wr_data to wr_addr at the clock edge
//  wr_addr      in   ADDR_W  write address
//  wr_data      in   DATA_W  write data (unit result z)
//  issue_en     in   1       marks issue_addr busy at the clock edge (result now in flight)
//  issue_addr   in   ADDR_W  destination register of the issued operation
// BEHAVIOUR
//  - Reset: on a clock edge with rst=1, all NREGS registers are cleared to 0 and all busy
//    bits are cleared. rst has priority over wr_en and issue_en in the same cycle.
//    After reset, rd_data_* = 0 and busy_* = 0 for every address.
//  - Register 0: always reads 0 and is never busy. Writes and issues to address 0 are
//    dropped with no state change.
//  - Write: if wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data at the edge.
//    One-cycle write latency.
//  - Read: combinational, zero latency. rd_data_x = mem[rd_addr_x], with one exception:
//    if wr_en=1, wr_addr==rd_addr_x, and rd_addr_x!=0, then rd_data_x = wr_data.
//    This is the same-cycle bypass. Ports A and B are independent; both may read the
//    same address.
//  - Scoreboard, next state per register r (r!=0):
//      rst                              -> busy[r] <= 0
//      issue_en & issue_addr==r         -> busy[r] <= 1   (issue wins over a same-r write)
//      else wr_en & wr_addr==r          -> busy[r] <= 0
//      else                             -> hold
//  - busy_x = busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x).
//    A same-cycle writeback clears busy_x combinationally, because its data is bypassed.
//    A same-cycle issue does not raise busy_x; the bit is visible from the next cycle.
//  - A write to a non-busy register is legal: data updates, busy stays 0.
//  - Reset mid-operation discards all in-flight busy state. Writebacks arriving after
//    reset are ordinary writes.
//  - No X propagation. Addresses are always in range because NREGS = 2**ADDR_W.
// STRUCTURE
//  - Shared package cpu_pkg: DATA_W, ADDR_W, NREGS, REG_ZERO = 0.
//  - One sub-module, rf_scoreboard: holds the busy[NREGS-1:0] vector and the busy_a/busy_b
//    logic. The top level holds the storage array and the bypass muxes.
// TESTING
//  1 Reset: rst=1 for 1 cycle, then sweep rd_addr_a/b over 0..31
//    -> every rd_data = 32'h00000000 and every busy = 0.
//  2 Write/read: write r5=32'h11111111, next cycle read A=5, B=0
//    -> rd_data_a = 32'h11111111, rd_data_b = 0.
//  3 Bypass: wr_en=1, wr_addr=7, wr_data=32'hffffffff, rd_addr_a=7 in the same cycle
//    -> rd_data_a = 32'hffffffff in that cycle. Also write r0=32'hffffffff
//    -> r0 still reads 0.
//  4 Scoreboard: issue r3; next cycle busy_a(A=3) = 1. Writeback r3=32'h11111111
//    -> busy_a = 0 and rd_data_a = 32'h11111111 in that same cycle; busy[3] stays 0 after.
//  5 Collision: issue_en and wr_en both to r9 in one cycle
//    -> next cycle busy[9] = 1 and r9 = wr_data. Issue r0 -> busy never set.
//  6 Reset priority: r4 busy and holding 32'h11111111; rst=1 with wr_en to r4
//    -> next cycle r4 = 0, busy_a(A=4) = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants.
// DATA_W matches the a/b/z operand width of the logic/arithmetic units, and
// ADDR_W sizes the integer register file. REG_ZERO is the architectural zero
// register: it always reads 0, is never busy, and ignores writes and issues.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 2 ** ADDR_W;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the integer register file.
// Each register has one busy bit. The bit is set when an operation that targets
// the register is issued, and cleared when its result is written back. The bit
// for register 0 is never set.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   rd_addr_a, rd_addr_b   read port addresses
//   busy_a, busy_b         the addressed register still waits for a result
//   wr_en, wr_addr         writeback strobe and address; clears busy
//   issue_en, issue_addr   issue strobe and destination address; sets busy
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0] busy;

  // The clear from the writeback comes first and the set from the issue comes
  // second. If both target the same register in one cycle, the set wins. That
  // register then waits for the result of the newly issued operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_en && (wr_addr != ZERO_ADDR)) begin
        busy[wr_addr] <= 1'b0;
      end
      if (issue_en && (issue_addr != ZERO_ADDR)) begin
        busy[issue_addr] <= 1'b1;
      end
    end
  end

  // A writeback in the same cycle hides the busy bit because the read ports
  // bypass its data. An issue in the same cycle shows up only from the next cycle.
  always_comb begin
    busy_a = busy[rd_addr_a] & ~(wr_en && (wr_addr == rd_addr_a));
    busy_b = busy[rd_addr_b] & ~(wr_en && (wr_addr == rd_addr_b));
  end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Integer register file with two read ports, one write port and a scoreboard.
// The read ports feed the a/b operands of the execution units, and unit results
// return on the write port. Reads are combinational and bypass a write to the
// same address in the same cycle. Register 0 is hardwired to zero.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   rd_addr_a/rd_data_a/busy_a     read port A: address, data, pending flag
//   rd_addr_b/rd_data_b/busy_b     read port B: address, data, pending flag
//   wr_en, wr_addr, wr_data        synchronous write port (unit result z)
//   issue_en, issue_addr           marks a destination register as in flight
module regfile_2r1w_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // The register array is cleared on reset. Reset takes priority over a write
  // in the same cycle. Writes to register 0 are dropped, so mem[0] stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read muxes forward the write data when a read and a write hit the same
  // address in one cycle. This lets a result reach a consumer without waiting
  // for the write edge. Register 0 is forced to zero so a write to r0 is never
  // forwarded.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != ZERO_ADDR) begin
      rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : mem[rd_addr_a];
    end
    if (rd_addr_b != ZERO_ADDR) begin
      rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : mem[rd_addr_b];
    end
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .busy_a    (busy_a),
    .rd_addr_b (rd_addr_b),
    .busy_b    (busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .issue_en  (issue_en),
    .issue_addr(issue_addr)
  );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed testbench for regfile_2r1w_sb.
// Inputs change 1 ns after each rising edge, and outputs are checked 1 ns
// later, in the middle of the cycle. Expected values are worked out by hand.
module tb_regfile_2r1w_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, issue_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data;
  logic        busy_a, busy_b, wr_en, issue_en;

  int checks = 0;
  int errors = 0;

  regfile_2r1w_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .busy_a    (busy_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .busy_b    (busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .issue_en  (issue_en),
    .issue_addr(issue_addr)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Drives one cycle of inputs just after a rising edge. Any state change from
  // these inputs happens at the following edge.
  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                               input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia; rd_addr_a = ra; rd_addr_b = rb;
    #1;
  endtask

  // Counts one comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; rd_addr_a = '0; rd_addr_b = '0;

    // 1: reset, then sweep every address on both ports
    $display("[TB] reset sweep");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      checkOutput("rst_data_a", rd_data_a, 32'h0);
      checkOutput("rst_data_b", rd_data_b, 32'h0);
      checkOutput("rst_busy_a", {31'b0, busy_a}, 32'h0);
      checkOutput("rst_busy_b", {31'b0, busy_b}, 32'h0);
    end

    // 2: write r5, read it on the next cycle; a write to a non-busy register keeps busy at 0
    $display("[TB] write/read");
    applyStimulus(0, 1, 5, 32'h11111111, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("wr_rd_a", rd_data_a, 32'h11111111);
    checkOutput("wr_rd_b0", rd_data_b, 32'h0);
    checkOutput("wr_busy_a", {31'b0, busy_a}, 32'h0);

    // 3: same-cycle bypass; r0 ignores writes and is not bypassed
    $display("[TB] bypass");
    applyStimulus(0, 1, 7, 32'hffffffff, 0, 0, 7, 5);
    checkOutput("byp_a", rd_data_a, 32'hffffffff);
    checkOutput("byp_b_other", rd_data_b, 32'h11111111);
    applyStimulus(0, 1, 0, 32'hffffffff, 0, 0, 0, 7);
    checkOutput("r0_byp_a", rd_data_a, 32'h0);
    checkOutput("r7_stored_b", rd_data_b, 32'hffffffff);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_after_a", rd_data_a, 32'h0);

    // 4: scoreboard set by an issue, cleared by a writeback with bypassed data
    $display("[TB] scoreboard");
    applyStimulus(0, 0, 0, 0, 1, 3, 3, 3);
    checkOutput("iss_same_cyc_a", {31'b0, busy_a}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 5);
    checkOutput("iss_busy_a", {31'b0, busy_a}, 32'h1);
    checkOutput("iss_other_b", {31'b0, busy_b}, 32'h0);
    checkOutput("iss_old_data", rd_data_a, 32'h0);
    applyStimulus(0, 1, 3, 32'h11111111, 0, 0, 3, 3);
    checkOutput("wb_busy_a", {31'b0, busy_a}, 32'h0);
    checkOutput("wb_busy_b", {31'b0, busy_b}, 32'h0);
    checkOutput("wb_data_a", rd_data_a, 32'h11111111);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 3);
    checkOutput("wb_after_busy", {31'b0, busy_a}, 32'h0);
    checkOutput("wb_after_data", rd_data_b, 32'h11111111);

    // 5: issue and write to r9 in the same cycle, then an issue to r0
    $display("[TB] collision");
    applyStimulus(0, 1, 9, 32'h12345678, 1, 9, 9, 0);
    checkOutput("col_busy_same", {31'b0, busy_a}, 32'h0);
    checkOutput("col_byp_data", rd_data_a, 32'h12345678);
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 9);
    checkOutput("col_busy_a", {31'b0, busy_a}, 32'h1);
    checkOutput("col_busy_b", {31'b0, busy_b}, 32'h1);
    checkOutput("col_data", rd_data_a, 32'h12345678);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9);
    checkOutput("r0_never_busy", {31'b0, busy_a}, 32'h0);
    checkOutput("r9_still_busy", {31'b0, busy_b}, 32'h1);

    // 6: reset overrides a same-cycle write and clears in-flight state
    $display("[TB] reset priority");
    applyStimulus(0, 1, 4, 32'h11111111, 1, 4, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 4);
    checkOutput("pre_rst_busy", {31'b0, busy_a}, 32'h1);
    checkOutput("pre_rst_data", rd_data_b, 32'h11111111);
    applyStimulus(1, 1, 4, 32'hdeadbeef, 0, 0, 4, 9);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 9);
    checkOutput("rst_pri_data", rd_data_a, 32'h0);
    checkOutput("rst_pri_busy", {31'b0, busy_a}, 32'h0);
    checkOutput("rst_r9_busy", {31'b0, busy_b}, 32'h0);
    checkOutput("rst_r9_data", rd_data_b, 32'h0);
    applyStimulus(0, 1, 9, 32'hcafef00d, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 7);
    checkOutput("late_wb_data", rd_data_a, 32'hcafef00d);
    checkOutput("late_wb_busy", {31'b0, busy_a}, 32'h0);
    checkOutput("r7_cleared", rd_data_b, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
